// File: rtl/async_hs_pkg.sv
// Shared types and defaults for the 4-phase bundled-data link to the C-element pipeline.
package async_hs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } hs_state_e;

  localparam int DEF_DATA_W      = 4;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/hs_sync.sv
// Multi-flop synchronizer for a single asynchronous level; STAGES edges of latency, no backpressure.
module hs_sync
  import async_hs_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clock,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_hs_tx.sv
// Valid/ready to 4-phase bundled-data initiator: data_o one cycle after push, req_o after two.
// Backpressure: in_ready drops when the FIFO is full; the FSM stalls on the synchronized ack.
module async_hs_tx
  import async_hs_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              req_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ack_i,
  output logic              busy,
  output logic              proto_err,
  output logic [CNT_W-1:0]  tx_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic ack_s;

  hs_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clock (clock),
    .rst_n (rst_n),
    .d_i   (ack_i),
    .q_o   (ack_s)
  );

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push;
  logic              pop;

  hs_state_e         state_q, state_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Both flags come from registered state only, so a push can never meet its own pop.
  assign in_ready = (count_q != FULL_CNT);
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == IDLE) && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = SETUP;
      SETUP:   state_d = REQ_HI;
      REQ_HI:  if (ack_s) state_d = REQ_LO;
      REQ_LO:  if (!ack_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req is registered from the next state so the async side only ever sees a flop output.
  always_comb begin
    req_d  = (state_d == REQ_HI);
    data_d = pop ? mem_q[rd_ptr_q] : data_q;
    err_d  = err_q | (ack_s && ((state_q == IDLE) || (state_q == SETUP)));
    cnt_d  = ((state_q == REQ_LO) && !ack_s) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  assign req_o     = req_q;
  assign data_o    = data_q;
  assign proto_err = err_q;
  assign tx_count  = cnt_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_async_hs_tx.sv
// Directed bench for async_hs_tx with a word scoreboard and an emulated C-element responder.
module tb_async_hs_tx;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_ready;
  logic       req_o;
  logic [3:0] data_o;
  logic       ack_i = 1'b0;
  logic       busy;
  logic       proto_err;
  logic [7:0] tx_count;

  async_hs_tx dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .req_o     (req_o),
    .data_o    (data_o),
    .ack_i     (ack_i),
    .busy      (busy),
    .proto_err (proto_err),
    .tx_count  (tx_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // responder controls (written by the stimulus block only)
  logic auto_ack = 1'b0;
  logic ack_man  = 1'b0;
  logic rnd_ack  = 1'b0;
  int   ack_dly  = 0;

  // monitor state (written by the monitor only)
  logic [3:0] obs_arr [1024];
  int         rx_n = 0;
  int         stab_err = 0;
  logic       prev_req = 1'b0;
  logic [3:0] prev_data = 4'h0;
  int         wait_cnt = 0;

  logic [3:0] exp_q [$];
  int         rd_i = 0;
  int         exp_tx = 0;

  // Emulated async pipeline: follows req after a programmable delay, or a manual level.
  always @(negedge clock) begin
    if (!auto_ack) begin
      ack_i = ack_man;
      wait_cnt = ack_dly;
    end else if (req_o !== ack_i) begin
      if (wait_cnt <= 0) begin
        ack_i = req_o;
        wait_cnt = rnd_ack ? int'($urandom_range(0, 7)) : ack_dly;
      end else begin
        wait_cnt = wait_cnt - 1;
      end
    end
  end

  always @(negedge clock) begin
    if (rst_n) begin
      if (req_o && !prev_req) begin
        obs_arr[rx_n % 1024] = data_o;
        rx_n = rx_n + 1;
      end
      if (req_o && prev_req && (data_o !== prev_data)) begin
        stab_err = stab_err + 1;
      end
    end
    prev_req = req_o;
    prev_data = data_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [3:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data = w;
    while (!in_ready && n < 400) begin
      tick();
      n++;
    end
    check("push_ready", in_ready, 1);
    @(posedge clock);
    exp_q.push_back(w);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 4000) begin
      tick();
      n++;
    end
    check(tag, busy, 0);
    tick();
  endtask

  task automatic drain_sb(input string tag);
    logic [3:0] got;
    logic [3:0] exp;
    while (rd_i < rx_n) begin
      got = obs_arr[rd_i % 1024];
      rd_i++;
      check({tag, "_expected_avail"}, exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check({tag, "_word"}, got, exp);
      end
    end
  endtask

  initial begin
    // reset with in_valid held high
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 4'hF;
    repeat (3) tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_req", req_o, 0);
    check("rst_data", data_o, 0);
    check("rst_busy", busy, 0);
    check("rst_err", proto_err, 0);
    check("rst_tx_count", tx_count, 0);
    repeat (3) tick();
    check("rst_no_push", busy, 0);
    check("rst_no_req", req_o, 0);

    // single word timing
    auto_ack = 1'b1;
    ack_dly = 1;
    push_word(4'hA);
    tick();
    check("single_data_t1", data_o, 4'hA);
    check("single_req_t1", req_o, 0);
    tick();
    check("single_req_t2", req_o, 1);
    check("single_data_t2", data_o, 4'hA);
    wait_idle("single_idle");
    drain_sb("single");
    exp_tx = exp_tx + 1;
    check("single_tx_count", tx_count, 32'(exp_tx % 256));
    check("single_data_held", data_o, 4'hA);

    // burst with ack withheld
    auto_ack = 1'b0;
    ack_man = 1'b0;
    for (int i = 1; i <= 5; i++) push_word(4'(i));
    check("burst_full", in_ready, 0);
    check("burst_req_stuck", req_o, 1);
    in_valid = 1'b1;
    in_data = 4'h6;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("burst_stall", in_ready, 0);
    end
    in_valid = 1'b0;
    ack_dly = 0;
    auto_ack = 1'b1;
    push_word(4'h6);
    wait_idle("burst_idle");
    drain_sb("burst");
    check("burst_all_delivered", exp_q.size(), 0);
    exp_tx = exp_tx + 6;
    check("burst_tx_count", tx_count, 32'(exp_tx % 256));

    // spurious ack in IDLE
    auto_ack = 1'b0;
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    repeat (4) tick();
    check("perr_set", proto_err, 1);
    check("perr_fsm_idle", busy, 0);
    auto_ack = 1'b1;
    push_word(4'h7);
    wait_idle("perr_idle");
    drain_sb("perr");
    exp_tx = exp_tx + 1;
    check("perr_sticky", proto_err, 1);
    check("perr_tx_count", tx_count, 32'(exp_tx % 256));

    // reset while REQ_HI
    auto_ack = 1'b0;
    ack_man = 1'b0;
    push_word(4'h9);
    begin
      int n = 0;
      while (!req_o && n < 50) begin
        tick();
        n++;
      end
    end
    check("mid_req_seen", req_o, 1);
    tick();
    drain_sb("mid");
    rst_n = 1'b0;
    tick();
    check("mid_rst_req", req_o, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx", tx_count, 0);
    check("mid_rst_err", proto_err, 0);
    rst_n = 1'b1;
    exp_q.delete();
    exp_tx = 0;
    tick();
    auto_ack = 1'b1;
    push_word(4'h3);
    wait_idle("mid_idle");
    drain_sb("mid_after");
    exp_tx = exp_tx + 1;
    check("mid_tx_count", tx_count, 32'(exp_tx % 256));
    check("mid_err_clear", proto_err, 0);

    // counter wrap with random ack delays
    rnd_ack = 1'b1;
    for (int i = 0; i < 255; i++) begin
      push_word(4'($urandom_range(0, 15)));
      exp_tx = exp_tx + 1;
    end
    wait_idle("wrap_idle");
    drain_sb("wrap");
    check("wrap_all_delivered", exp_q.size(), 0);
    check("wrap_tx_count", tx_count, 32'(exp_tx % 256));
    check("wrap_zero", tx_count, 0);
    check("data_stable_while_req", stab_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
